// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, alu_ctl one-hot bit indices and sequencer state encodings.
package alu_pkg;

    localparam int ALU_W = 14;
    localparam int OP_W  = 5;
    localparam int CNT_W = 6;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    localparam int IDX_ADD   = 0;
    localparam int IDX_SUB   = 1;
    localparam int IDX_MUL   = 2;
    localparam int IDX_DIV   = 3;
    localparam int IDX_AND   = 4;
    localparam int IDX_OR    = 5;
    localparam int IDX_SHR   = 6;
    localparam int IDX_SHRA  = 7;
    localparam int IDX_SHL   = 8;
    localparam int IDX_ROR   = 9;
    localparam int IDX_ROL   = 10;
    localparam int IDX_NEG   = 11;
    localparam int IDX_NOT   = 12;
    localparam int IDX_INCPC = 13;

    localparam logic [ALU_W-1:0] CTL_INCPC = ALU_W'(1) << IDX_INCPC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot alu_ctl select plus an illegal-opcode flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  opcode,
    output logic [ALU_W-1:0] onehot,
    output logic             illegal
);

    always_comb begin
        onehot  = '0;
        illegal = 1'b0;
        case (opcode)
            OP_ADD:  onehot[IDX_ADD]  = 1'b1;
            OP_SUB:  onehot[IDX_SUB]  = 1'b1;
            OP_SHR:  onehot[IDX_SHR]  = 1'b1;
            OP_SHRA: onehot[IDX_SHRA] = 1'b1;
            OP_SHL:  onehot[IDX_SHL]  = 1'b1;
            OP_ROR:  onehot[IDX_ROR]  = 1'b1;
            OP_ROL:  onehot[IDX_ROL]  = 1'b1;
            OP_AND:  onehot[IDX_AND]  = 1'b1;
            OP_OR:   onehot[IDX_OR]   = 1'b1;
            OP_MUL:  onehot[IDX_MUL]  = 1'b1;
            OP_DIV:  onehot[IDX_DIV]  = 1'b1;
            OP_NEG:  onehot[IDX_NEG]  = 1'b1;
            OP_NOT:  onehot[IDX_NOT]  = 1'b1;
            default: illegal          = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU control sequencer: IDLE -> EXEC -> (WAIT) -> WB with pending IncPC requests.
// Define ALU_MULDIV_WAIT_EN to hold MUL/DIV for MULDIV_CYCLES cycles via the WAIT state.
//
// state | meaning
// IDLE  | accept start / serve pending IncPC; alu_ctl all-zero
// EXEC  | first cycle of the selected operation
// WAIT  | MUL/DIV extension cycles (only with ALU_MULDIV_WAIT_EN)
// WB    | load Z registers, pulse done
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  opcode,
    input  logic             inc_pc_req,
    output logic [ALU_W-1:0] alu_ctl,
    output logic             zlow_in,
    output logic             zhigh_in,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    logic [ALU_W-1:0] dec_onehot;
    logic             dec_illegal;

    alu_op_decode u_decode (
        .opcode  (opcode),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             pend_q, pend_d;
    logic [ALU_W-1:0] alu_ctl_q, alu_ctl_d;
    logic             zlow_q, zlow_d;
    logic             zhigh_q, zhigh_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic             muldiv_act;

`ifdef ALU_MULDIV_WAIT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // op_q is stale while IncPC runs, so the IncPC bit masks it out
    assign muldiv_act = !alu_ctl_q[IDX_INCPC] && is_muldiv(op_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pend_d    = pend_q;
        alu_ctl_d = alu_ctl_q;
        illegal_d = 1'b0;
`ifdef ALU_MULDIV_WAIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                alu_ctl_d = '0;
                // a pending IncPC is served before any new start
                if (pend_q || (inc_pc_req && !start)) begin
                    state_d   = ST_EXEC;
                    alu_ctl_d = CTL_INCPC;
                    pend_d    = 1'b0;
                end else if (start) begin
                    pend_d = inc_pc_req;
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d   = ST_EXEC;
                        op_d      = opcode;
                        alu_ctl_d = dec_onehot;
                    end
                end
            end
            ST_EXEC: begin
                pend_d = pend_q | inc_pc_req;
`ifdef ALU_MULDIV_WAIT_EN
                if (muldiv_act) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_WB;
                end
`else
                state_d = ST_WB;
`endif
            end
`ifdef ALU_MULDIV_WAIT_EN
            ST_WAIT: begin
                pend_d = pend_q | inc_pc_req;
                // cnt_q counts cycles held so far, EXEC included
                if (cnt_q >= CNT_LAST) begin
                    state_d = ST_WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_WB: begin
                pend_d    = pend_q | inc_pc_req;
                state_d   = ST_IDLE;
                alu_ctl_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                alu_ctl_d = '0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_WB);
        zlow_d  = (state_d == ST_WB);
        zhigh_d = (state_d == ST_WB) && muldiv_act;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            pend_q    <= 1'b0;
            alu_ctl_q <= '0;
            zlow_q    <= 1'b0;
            zhigh_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_MULDIV_WAIT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pend_q    <= pend_d;
            alu_ctl_q <= alu_ctl_d;
            zlow_q    <= zlow_d;
            zhigh_q   <= zhigh_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef ALU_MULDIV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign alu_ctl  = alu_ctl_q;
    assign zlow_in  = zlow_q;
    assign zhigh_in = zhigh_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: opcode vector table plus IncPC, busy-start and reset sequences.
module tb_alu_sequencer;

    localparam int MC = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  opcode;
    logic        inc_pc_req;
    logic [13:0] alu_ctl;
    logic        zlow_in, zhigh_in, busy, done, illegal;

    int total = 0;
    int bad   = 0;

    alu_sequencer #(.MULDIV_CYCLES(MC)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .inc_pc_req (inc_pc_req),
        .alu_ctl    (alu_ctl),
        .zlow_in    (zlow_in),
        .zhigh_in   (zhigh_in),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op;
        logic [13:0] ctl;
        logic        ill;
        logic        mdv;
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_ctl"}, 32'(alu_ctl), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_zlow"}, 32'(zlow_in), 0);
        chk({nm, "_zhigh"}, 32'(zhigh_in), 0);
    endtask

    function automatic int exp_len(input logic mdv);
`ifdef ALU_MULDIV_WAIT_EN
        return mdv ? MC : 1;
`else
        return 1;
`endif
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        int held_bad;
        start  = 1'b1;
        opcode = v.op;
        tick();
        start  = 1'b0;
        opcode = 5'd0;
        if (v.ill) begin
            chk("ill_pulse", 32'(illegal), 1);
            chk("ill_busy", 32'(busy), 0);
            chk("ill_ctl", 32'(alu_ctl), 0);
            tick();
            chk("ill_clear", 32'(illegal), 0);
            chk_idle("ill_after");
        end else begin
            chk("exec_ctl", 32'(alu_ctl), 32'(v.ctl));
            chk("exec_busy", 32'(busy), 1);
            chk("exec_ill", 32'(illegal), 0);
            n = 0;
            held_bad = 0;
            while (done !== 1'b1 && n < 200) begin
                if (alu_ctl !== v.ctl) held_bad++;
                n++;
                tick();
            end
            chk("op_len", 32'(n), 32'(exp_len(v.mdv)));
            chk("held_ctl_errs", 32'(held_bad), 0);
            chk("wb_zlow", 32'(zlow_in), 1);
            chk("wb_zhigh", 32'(zhigh_in), 32'(v.mdv));
            chk("wb_ctl", 32'(alu_ctl), 32'(v.ctl));
            tick();
            chk_idle("post_wb");
        end
    endtask

    initial begin
        int n;
        int dones;

        vecs[0]  = '{5'b00011, 14'h0001, 1'b0, 1'b0};
        vecs[1]  = '{5'b00100, 14'h0002, 1'b0, 1'b0};
        vecs[2]  = '{5'b00101, 14'h0040, 1'b0, 1'b0};
        vecs[3]  = '{5'b00110, 14'h0080, 1'b0, 1'b0};
        vecs[4]  = '{5'b00111, 14'h0100, 1'b0, 1'b0};
        vecs[5]  = '{5'b01000, 14'h0200, 1'b0, 1'b0};
        vecs[6]  = '{5'b01001, 14'h0400, 1'b0, 1'b0};
        vecs[7]  = '{5'b01010, 14'h0010, 1'b0, 1'b0};
        vecs[8]  = '{5'b01011, 14'h0020, 1'b0, 1'b0};
        vecs[9]  = '{5'b01111, 14'h0004, 1'b0, 1'b1};
        vecs[10] = '{5'b10000, 14'h0008, 1'b0, 1'b1};
        vecs[11] = '{5'b10001, 14'h0800, 1'b0, 1'b0};
        vecs[12] = '{5'b10010, 14'h1000, 1'b0, 1'b0};
        vecs[13] = '{5'b11111, 14'h0000, 1'b1, 1'b0};
        vecs[14] = '{5'b00000, 14'h0000, 1'b1, 1'b0};
        vecs[15] = '{5'b01100, 14'h0000, 1'b1, 1'b0};
        vecs[16] = '{5'b01110, 14'h0000, 1'b1, 1'b0};
        vecs[17] = '{5'b10011, 14'h0000, 1'b1, 1'b0};
        vecs[18] = '{5'b00010, 14'h0000, 1'b1, 1'b0};

        reset      = 1'b1;
        start      = 1'b0;
        opcode     = 5'd0;
        inc_pc_req = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_ill", 32'(illegal), 0);
        reset = 1'b0;
        tick();
        chk_idle("post_reset");

        for (int i = 0; i < 19; i++) run_vec(vecs[i]);

        // start + inc_pc_req together: AND first, then IncPC ahead of a new start
        start      = 1'b1;
        opcode     = 5'b01010;
        inc_pc_req = 1'b1;
        tick();
        start      = 1'b0;
        inc_pc_req = 1'b0;
        chk("and_exec", 32'(alu_ctl), 32'h0010);
        tick();
        chk("and_done", 32'(done), 1);
        chk("and_zhigh", 32'(zhigh_in), 0);
        start  = 1'b1;
        opcode = 5'b00011;
        tick();
        chk_idle("and_idle");
        tick();
        start = 1'b0;
        chk("incpc_ctl", 32'(alu_ctl), 32'h2000);
        chk("incpc_busy", 32'(busy), 1);
        chk("incpc_ill", 32'(illegal), 0);
        tick();
        chk("incpc_done", 32'(done), 1);
        chk("incpc_zlow", 32'(zlow_in), 1);
        chk("incpc_zhigh", 32'(zhigh_in), 0);
        tick();
        chk_idle("incpc_idle");
        tick();
        chk_idle("incpc_nofollow");

        // standalone IncPC with repeated requests while busy collapsing to one
        inc_pc_req = 1'b1;
        tick();
        chk("inc1_ctl", 32'(alu_ctl), 32'h2000);
        tick();
        chk("inc1_done", 32'(done), 1);
        inc_pc_req = 1'b0;
        tick();
        chk_idle("inc1_idle");
        tick();
        chk("inc2_ctl", 32'(alu_ctl), 32'h2000);
        tick();
        chk("inc2_done", 32'(done), 1);
        tick();
        chk_idle("inc2_idle");
        tick();
        chk_idle("inc_collapsed");

        // start while busy is ignored: exactly one done
        start  = 1'b1;
        opcode = 5'b00100;
        tick();
        opcode = 5'b00011;
        tick();
        chk("busy_sub_wb_ctl", 32'(alu_ctl), 32'h0002);
        chk("busy_sub_done", 32'(done), 1);
        start  = 1'b0;
        dones  = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("busy_sub_dones", 32'(dones), 1);
        start  = 1'b1;
        opcode = 5'b00100;
        tick();
        opcode = 5'b11111;
        tick();
        chk("busy_ill_ignored", 32'(illegal), 0);
        start = 1'b0;
        tick();
        chk_idle("busy_ill_idle");

        // asynchronous reset in the middle of a DIV
        start  = 1'b1;
        opcode = 5'b10000;
        tick();
        start = 1'b0;
`ifdef ALU_MULDIV_WAIT_EN
        tick();
        tick();
        chk("div_wait_ctl", 32'(alu_ctl), 32'h0008);
`else
        chk("div_exec_ctl", 32'(alu_ctl), 32'h0008);
`endif
        #2 reset = 1'b1;
        #1;
        chk_idle("async_reset");
        chk("async_reset_ill", 32'(illegal), 0);
        tick();
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done === 1'b1 || zlow_in === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 0);
        run_vec('{5'b00100, 14'h0002, 1'b0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
